mc_controller: RTL and testbench
================================

# mc_controller

Main control unit for the multicycle MIPS processor. A Moore FSM that sequences the shared datapath (single memory port, single ALU, PC/IR/A/B/ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps, one state per cycle. It decodes `op`/`funct` from the instruction register and drives every mux select and write enable of the datapath, plus the memory write strobe.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `op` input 6: `instr[31:26]` from the instruction register.
- `funct` input 6: `instr[5:0]` from the instruction register.
- `zero` input 1: ALU zero flag, combinational from the current cycle.
- `memtoreg` output 1: 0 selects ALUOut, 1 selects Data for the register write.
- `regdst` output 1: 0 selects rt, 1 selects rd as the write register.
- `iord` output 1: 0 selects PC, 1 selects ALUOut as the memory address.
- `pcsrc` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alusrca` output 1: 0 selects PC, 1 selects A.
- `alusrcb` output 2: 00 B, 01 constant 4, 10 signimm, 11 signimm<<2.
- `alucontrol` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `irwrite` output 1: IR load enable.
- `regwrite` output 1: register file write enable.
- `memwrite` output 1: memory write strobe.
- `pcen` output 1: PC load enable.
- `state` output 4: current state encoding, for debug and verification.

## Operation
- State register is 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Encodings 12–15 are unused and go to FETCH.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=add. This precomputes the branch target into ALUOut.
  - Next state for lw (100011) or sw (101011): MEMADR.
  - R-type (000000): RTYPEEX.
  - beq (000100): BEQEX.
  - addi (001000): ADDIEX.
  - j (000010): JEX.
  - Any other opcode: FETCH. No register or memory write occurs.
- MEMADR: alusrca=1, alusrcb=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=funct, then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JEX: pcsrc=10, pcwrite=1, then FETCH.
- `pcen = pcwrite | (branch & zero)`.
- Any select not listed for a state is driven 0. `alucontrol` defaults to 010.
- ALU decoder:
  - aluop=add gives 010; aluop=sub gives 110.
  - aluop=funct maps funct 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct gives 010.
- All outputs are decoded from the state register only (Moore). The exceptions are `pcen`, which also uses `zero`, and `alucontrol`, which also uses `funct` in RTYPEEX.

## Timing
- Instruction latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset:
  - While `reset`=0 at a rising edge, the state becomes FETCH on that edge.
  - While `reset` is low, `irwrite`, `pcen`, `regwrite` and `memwrite` are forced 0. All other outputs take their FETCH values and `state`=0.
  - Asserting reset in any state, including mid-instruction, aborts the instruction with no further writes.
  - The first FETCH executes on the first edge with `reset`=1.
- `zero` is sampled combinationally in BEQEX only. In all other states, `zero` does not affect any output.

## Configuration
- `MC_BNE_EN` defined:
  - Opcode 000101 (bne) is decoded in DECODE to state BNEEX=12.
  - BNEEX has the same outputs as BEQEX, except `pcen = pcwrite | (branchne & ~zero)`.
  - bne latency is 3 cycles.
- `MC_BNE_EN` undefined: opcode 000101 is illegal (DECODE→FETCH) and encoding 12 is unused.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with op=100011 → `state`=0, all four enables 0. First edge after release → `state`=1.
- lw: op=100011 from reset → states 0,1,2,3,4,0. `iord`=1 in state 3. `regwrite`=1, `memtoreg`=1 only in state 4.
- R-type: op=000000 with each of the five functs → `alucontrol` in state 6 is 010/110/000/001/111. Funct 000000 → 010. `regwrite`=1 with `regdst`=1 in state 7.
- beq: op=000100 with `zero`=1 → `pcen`=1, `pcsrc`=01 in state 8. With `zero`=0 → `pcen`=0. Next state is 0 in both cases.
- Illegal/sw/j: op=111111 → 0,1,0 with no write enables. sw → `memwrite`=1 only in state 5. j → `pcsrc`=10, `pcen`=1 in state 11.
- Mid-op reset and bne: `reset`=0 during state 3 → next state 0, no `regwrite`. With `MC_BNE_EN`, op=000101 with `zero`=0 → state 12 with `pcen`=1. Without the macro → 0,1,0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS main control: Moore FSM sequencing the shared datapath plus ALU decode.
// Optional bne support is enabled by defining MC_BNE_EN.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       pcen,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MC_BNE_EN
        , BNEEX = 4'd12
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } aluop_t;

    state_t state_q;
    state_t state_d;
    state_t cur;
    aluop_t aluop;
    logic   irwrite_s;
    logic   regwrite_s;
    logic   memwrite_s;
    logic   pcwrite;
    logic   branch;
    logic   branchne;

    // State register; reset lands in FETCH on the edge
    always_ff @(posedge clk) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state sequencing
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // While reset is low the outputs present FETCH with all writes suppressed
    assign cur   = reset ? state_q : FETCH;
    assign state = 4'(cur);

    always_comb begin
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = ALU_ADD;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  regwrite_s = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                alusrca  = 1'b1;
                aluop    = ALU_SUB;
                pcsrc    = 2'b01;
                branchne = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // ALU decoder
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALU_SUB: alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign irwrite  = irwrite_s & reset;
    assign regwrite = regwrite_s & reset;
    assign memwrite = memwrite_s & reset;
    assign pcen     = (pcwrite | (branch & zero) | (branchne & ~zero)) & reset;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-path reference model, directed and random stimulus.
module tb_mc_controller;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ILL  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = LW;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       memtoreg, regdst, iord, alusrca, irwrite, regwrite, memwrite, pcen;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int idx = 0;

    int h_state[8], h_alu[8], h_pcen[8], h_pcsrc[8], h_iord[8];
    int h_regwrite[8], h_regdst[8], h_memtoreg[8], h_memwrite[8], h_irwrite[8];

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .pcen(pcen), .state(state)
    );

    always #5 clk = ~clk;

    // Number of cycles an instruction occupies, FETCH included
    function automatic int path_len(input logic [5:0] o);
        case (o)
            LW:               return 5;
            SW, RT, ADDI:     return 4;
            BEQ, JMP:         return 3;
`ifdef MC_BNE_EN
            BNE:              return 3;
`endif
            default:          return 2;
        endcase
    endfunction

    // State visited at step k of an instruction
    function automatic int path_state(input logic [5:0] o, input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (o)
            LW:   return (k == 2) ? 2 : ((k == 3) ? 3 : 4);
            SW:   return (k == 2) ? 2 : 5;
            RT:   return (k == 2) ? 6 : 7;
            BEQ:  return 8;
            ADDI: return (k == 2) ? 9 : 10;
            JMP:  return 11;
            BNE:  return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return 2;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    always @(posedge clk) begin
        if (!reset) idx <= 0;
        else if (idx + 1 < path_len(op)) idx <= idx + 1;
        else idx <= 0;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int s;
        int rl;
        rl = reset ? 1 : 0;
        s  = reset ? path_state(op, idx) : 0;
        chk("state", int'(state), s);
        chk("irwrite", int'(irwrite), (rl == 1 && s == 0) ? 1 : 0);
        chk("pcen", int'(pcen), (rl == 1 && (s == 0 || s == 11 || (s == 8 && zero) ||
                                   (s == 12 && !zero))) ? 1 : 0);
        chk("regwrite", int'(regwrite), (rl == 1 && (s == 4 || s == 7 || s == 10)) ? 1 : 0);
        chk("memwrite", int'(memwrite), (rl == 1 && s == 5) ? 1 : 0);
        chk("memtoreg", int'(memtoreg), (s == 4) ? 1 : 0);
        chk("regdst", int'(regdst), (s == 7) ? 1 : 0);
        chk("iord", int'(iord), (s == 3 || s == 5) ? 1 : 0);
        chk("pcsrc", int'(pcsrc), (s == 8 || s == 12) ? 1 : ((s == 11) ? 2 : 0));
        chk("alusrca", int'(alusrca), (s == 2 || s == 6 || s == 8 || s == 9 || s == 12) ? 1 : 0);
        chk("alusrcb", int'(alusrcb), (s == 0) ? 1 : ((s == 1) ? 3 : ((s == 2 || s == 9) ? 2 : 0)));
        chk("alucontrol", int'(alucontrol),
            (s == 6) ? funct_alu(funct) : ((s == 8 || s == 12) ? 6 : 2));
    end

    // One cycle: drive after the edge, sample after the falling edge
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z);
        @(posedge clk);
        #1;
        reset = r; op = o; funct = f; zero = z;
        @(negedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int len);
        for (int k = 0; k < len; k++) begin
            cyc(1'b1, o, f, z);
            h_state[k] = int'(state);       h_alu[k] = int'(alucontrol);
            h_pcen[k] = int'(pcen);         h_pcsrc[k] = int'(pcsrc);
            h_iord[k] = int'(iord);         h_regwrite[k] = int'(regwrite);
            h_regdst[k] = int'(regdst);     h_memtoreg[k] = int'(memtoreg);
            h_memwrite[k] = int'(memwrite); h_irwrite[k] = int'(irwrite);
        end
    endtask

    logic [5:0] rfuncts[6];
    int         ralu[6];
    logic [5:0] ops[8];
    logic [5:0] fl[5];

    initial begin
        rfuncts = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        ralu    = '{2, 6, 0, 1, 7, 2};
        ops     = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, ILL};
        fl      = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, LW, 6'b0, 1'b1);
            chk("rst_state", int'(state), 0);
            chk("rst_enables", int'({irwrite, pcen, regwrite, memwrite}), 0);
        end

        // lw straight out of reset
        instr(LW, 6'b0, 1'b0, 5);
        for (int k = 0; k < 5; k++) chk("lw_state", h_state[k], (k < 5) ? k : 0);
        chk("lw_iord3", h_iord[3], 1);
        chk("lw_regwrite3", h_regwrite[3], 0);
        chk("lw_regwrite4", h_regwrite[4], 1);
        chk("lw_memtoreg4", h_memtoreg[4], 1);
        chk("lw_irwrite0", h_irwrite[0], 1);

        // R-type across the funct table
        for (int i = 0; i < 6; i++) begin
            instr(RT, rfuncts[i], 1'b0, 4);
            chk("rt_first_state", h_state[0], 0);
            chk("rt_ex_state", h_state[2], 6);
            chk("rt_alu", h_alu[2], ralu[i]);
            chk("rt_wb", h_regwrite[3] * 2 + h_regdst[3], 3);
        end

        // beq taken and not taken
        instr(BEQ, 6'b0, 1'b1, 3);
        chk("beq_state", h_state[2], 8);
        chk("beq_pcen_z1", h_pcen[2], 1);
        chk("beq_pcsrc", h_pcsrc[2], 1);
        chk("beq_alu", h_alu[2], 6);
        instr(BEQ, 6'b0, 1'b0, 3);
        chk("beq_next", h_state[0], 0);
        chk("beq_pcen_z0", h_pcen[2], 0);

        // Illegal opcode, sw, j
        instr(ILL, 6'b0, 1'b0, 2);
        chk("ill_next", h_state[0], 0);
        chk("ill_state1", h_state[1], 1);
        chk("ill_writes", h_regwrite[1] + h_memwrite[1], 0);
        instr(SW, 6'b0, 1'b0, 4);
        chk("sw_first", h_state[0], 0);
        chk("sw_state", h_state[3], 5);
        chk("sw_memwrite2", h_memwrite[2], 0);
        chk("sw_memwrite3", h_memwrite[3], 1);
        instr(JMP, 6'b0, 1'b0, 3);
        chk("j_state", h_state[2], 11);
        chk("j_pcsrc", h_pcsrc[2], 2);
        chk("j_pcen", h_pcen[2], 1);

        // addi
        instr(ADDI, 6'b0, 1'b0, 4);
        chk("addi_state", h_state[3], 10);
        chk("addi_wb", h_regwrite[3] * 2 + h_regdst[3], 2);

        // bne with zero low
`ifdef MC_BNE_EN
        instr(BNE, 6'b0, 1'b0, 3);
        chk("bne_state", h_state[2], 12);
        chk("bne_pcen", h_pcen[2], 1);
`else
        instr(BNE, 6'b0, 1'b0, 2);
        chk("bne_illegal", h_state[1], 1);
`endif

        // Reset asserted while in MEMRD
        instr(LW, 6'b0, 1'b0, 3);
        chk("mid_state2", h_state[2], 2);
        cyc(1'b0, LW, 6'b0, 1'b0);
        chk("mid_rst_regwrite", int'(regwrite), 0);
        cyc(1'b1, LW, 6'b0, 1'b0);
        chk("mid_after_state", int'(state), 0);
        chk("mid_after_regwrite", int'(regwrite), 0);
        cyc(1'b1, LW, 6'b0, 1'b0);
        chk("mid_after_decode", int'(state), 1);

        // Randomized traffic; op/funct only change at instruction boundaries
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (idx == 0) begin
                op = ops[$urandom_range(0, 7)];
                if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
                funct = fl[$urandom_range(0, 4)];
                if ($urandom_range(0, 3) == 0) funct = 6'($urandom_range(0, 63));
            end
            reset = ($urandom_range(0, 63) != 0);
            zero  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
